signed_adder_rr_arbiter: RTL and testbench
==========================================

Name: signed_adder_rr_arbiter

Overview:
- Shares a single W-bit two's-complement adder with overflow detection between N_REQ requesters.
- Each requester offers an (a, b) operand pair over a valid/ready handshake. A round-robin arbiter grants one pair per cycle into a single registered result stage.
- The result stage carries sum, overflow and requester id to one consumer over a valid/ready handshake with backpressure.
- Also keeps a saturating count of overflowed results for status readout.

Parameters:
- N_REQ, 4, number of requesters (2..8)
- W, 4, operand and sum width in bits, two's complement
- CNT_W, 8, width of overflow event counter

Ports:
- clk  input  1  single clock, all state on rising edge
- rst_n  input  1  asynchronous active-low reset
- req_valid  input  N_REQ  requester i has an operand pair
- req_ready  output  N_REQ  requester i's pair is accepted this cycle
- req_a  input  N_REQ*W  operand a, requester i at bits [i*W +: W]
- req_b  input  N_REQ*W  operand b, same packing
- resp_valid  output  1  result register holds a valid result
- resp_ready  input  1  consumer accepts result this cycle
- resp_id  output  $clog2(N_REQ)  index of requester that produced the result
- resp_sum  output  W  a + b modulo 2^W
- resp_overflow  output  1  signed overflow of that addition
- ovf_count  output  CNT_W  number of results with overflow=1 delivered since reset, saturating
- clr_count  input  1  synchronous clear of ovf_count

Behaviour:
- Reset (rst_n=0, asynchronous):
  - resp_valid=0, resp_id=0, resp_sum=0, resp_overflow=0, ovf_count=0.
  - Round-robin pointer set to N_REQ-1, so requester 0 has top priority first.
  - req_ready is all 0 while reset is asserted.
- Slot free condition: slot_free = !resp_valid || resp_ready.
- Arbitration (combinational):
  - When slot_free is 1, scan requesters in order ptr+1, ptr+2, ... wrapping modulo N_REQ.
  - The first i with req_valid[i]=1 is granted; req_ready is one-hot at bit i.
  - If slot_free=0 or no req_valid is set, req_ready is all 0.
  - req_ready never depends on resp_valid alone when resp_ready=1, i.e. full throughput of 1 op/cycle.
- Accept (handshake req_valid[i] & req_ready[i] at an edge):
  - On that edge: resp_sum <= a_i + b_i truncated to W bits; resp_overflow <= (a_i[W-1]==b_i[W-1]) && (sum[W-1]!=a_i[W-1]); resp_id <= i; resp_valid <= 1; ptr <= i.
- Latency: exactly 1 cycle from accept edge to resp_valid visible.
- Drain:
  - On a resp_valid & resp_ready edge with no new accept, resp_valid <= 0.
  - With simultaneous accept, the new result replaces the old one in the same edge, with no bubble.
- Backpressure: while resp_valid=1 and resp_ready=0, resp_id, resp_sum and resp_overflow are held stable, and no new request is granted.
- The pointer changes only on accept; an idle cycle leaves it unchanged.
- Requesters must hold a and b stable while valid and not ready. The block does not register operands before the grant.
- ovf_count:
  - Increments by 1 on each edge where resp_valid & resp_ready & resp_overflow.
  - Saturates at 2^CNT_W-1.
  - When clr_count=1 it is cleared to 0 on the edge, and clear wins over a simultaneous increment.
- Sum width: no extension. -8 + -8 gives sum 0 with overflow=1. Mixed signs never overflow.
- Reset mid-operation clears the held result immediately. A pending result is lost and is not counted.

Test Plan:
- Reset, then req_valid=0001 with a0=3, b0=2, resp_ready=1 -> req_ready=0001 that cycle. Next cycle resp_valid=1, resp_id=0, resp_sum=5, resp_overflow=0.
- All four requesters valid continuously (a=4, b=7 on each), resp_ready=1 -> grants in order 0,1,2,3,0,... with one result per cycle. Each result has sum=4'hB and overflow=1, and ovf_count climbs by 1 per cycle.
- Result held with resp_ready=0 for 3 cycles while req_valid=1111 -> req_ready=0000. resp_* stay stable for 3 cycles. Raising resp_ready grants the next requester in the same cycle, with no bubble.
- Signed boundaries on requester 2: (-4,-7)->sum 5, ovf=1; (-4,-4)->sum -8, ovf=0; (7,-4)->sum 3, ovf=0; (-8,-8)->sum 0, ovf=1. resp_id=2 for all four.
- Set ovf_count to 254 via overflowing ops, then two more overflow deliveries -> count is 255 and stays there. clr_count together with an overflow delivery -> 0.
- Assert rst_n=0 asynchronously while resp_valid=1 and resp_ready=0 -> resp_valid=0 before the next edge, ovf_count=0. After release, requester 0 wins ahead of requester 3 when both are valid.

Source files
------------

// File: rtl/signed_adder_rr_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : signed_adder_rr_arbiter
// Description : One W-bit two's-complement adder shared by N_REQ requesters.
//               A round-robin arbiter grants one operand pair per cycle into a
//               registered result stage. The result stage drives a single
//               consumer through a valid/ready handshake with backpressure.
//               A saturating counter tracks delivered overflow results.
// Revision    : 1.0 - initial release
// ============================================================================
module signed_adder_rr_arbiter #(
    parameter int N_REQ = 4,
    parameter int W     = 4,
    parameter int CNT_W = 8
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic [N_REQ-1:0]           req_valid,
    output logic [N_REQ-1:0]           req_ready,
    input  logic [N_REQ*W-1:0]         req_a,
    input  logic [N_REQ*W-1:0]         req_b,
    output logic                       resp_valid,
    input  logic                       resp_ready,
    output logic [$clog2(N_REQ)-1:0]   resp_id,
    output logic [W-1:0]               resp_sum,
    output logic                       resp_overflow,
    output logic [CNT_W-1:0]           ovf_count,
    input  logic                       clr_count
);

    localparam int                 ID_W       = $clog2(N_REQ);
    // Pointer starts at the last requester so requester 0 is scanned first.
    localparam logic [ID_W-1:0]    c_PTR_RST  = ID_W'(N_REQ - 1);
    localparam logic [CNT_W-1:0]   c_CNT_MAX  = {CNT_W{1'b1}};

    logic [ID_W-1:0]   ptr_q, ptr_d;
    logic              resp_valid_q, resp_valid_d;
    logic [ID_W-1:0]   resp_id_q, resp_id_d;
    logic [W-1:0]      resp_sum_q, resp_sum_d;
    logic              resp_overflow_q, resp_overflow_d;
    logic [CNT_W-1:0]  ovf_count_q, ovf_count_d;

    logic              w_slot_free;
    logic              w_grant;
    logic [ID_W-1:0]   w_grant_idx;
    logic [N_REQ-1:0]  w_req_ready;
    logic [W-1:0]      w_a_sel;
    logic [W-1:0]      w_b_sel;
    logic [W-1:0]      w_sum;
    logic              w_ovf;
    logic              w_deliver_ovf;

    // Result slot can take a new pair if empty or being drained this cycle;
    // nothing is granted while reset is held.
    assign w_slot_free = rst_n && (!resp_valid_q || resp_ready);

    // Round-robin scan from ptr+1 upward (wrapping); first valid requester wins.
    always_comb begin
        w_grant     = 1'b0;
        w_grant_idx = '0;
        w_req_ready = '0;
        w_a_sel     = '0;
        w_b_sel     = '0;
        if (w_slot_free) begin
            for (int k = 1; k <= N_REQ; k++) begin
                for (int i = 0; i < N_REQ; i++) begin
                    if (!w_grant && req_valid[i]
                        && (((int'(ptr_q) + k) % N_REQ) == i)) begin
                        w_grant        = 1'b1;
                        w_grant_idx    = ID_W'(i);
                        w_req_ready[i] = 1'b1;
                        w_a_sel        = req_a[i*W +: W];
                        w_b_sel        = req_b[i*W +: W];
                    end
                end
            end
        end
    end

    // Modulo-2^W sum; overflow when like-signed operands give an opposite-signed sum.
    always_comb begin
        w_sum = w_a_sel + w_b_sel;
        w_ovf = (w_a_sel[W-1] == w_b_sel[W-1]) && (w_sum[W-1] != w_a_sel[W-1]);
    end

    // Result stage next state: a grant loads (and may replace a draining result),
    // otherwise a drain empties the slot, otherwise hold.
    always_comb begin
        ptr_d           = ptr_q;
        resp_valid_d    = resp_valid_q;
        resp_id_d       = resp_id_q;
        resp_sum_d      = resp_sum_q;
        resp_overflow_d = resp_overflow_q;
        if (w_grant) begin
            ptr_d           = w_grant_idx;
            resp_valid_d    = 1'b1;
            resp_id_d       = w_grant_idx;
            resp_sum_d      = w_sum;
            resp_overflow_d = w_ovf;
        end else if (resp_valid_q && resp_ready) begin
            resp_valid_d    = 1'b0;
        end
    end

    // Overflow counter: clear has priority, increment saturates at all-ones.
    always_comb begin
        w_deliver_ovf = resp_valid_q && resp_ready && resp_overflow_q;
        ovf_count_d   = ovf_count_q;
        if (clr_count) begin
            ovf_count_d = '0;
        end else if (w_deliver_ovf && (ovf_count_q != c_CNT_MAX)) begin
            ovf_count_d = ovf_count_q + 1'b1;
        end
    end

    // State registers with asynchronous clear.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ptr_q           <= c_PTR_RST;
            resp_valid_q    <= 1'b0;
            resp_id_q       <= '0;
            resp_sum_q      <= '0;
            resp_overflow_q <= 1'b0;
            ovf_count_q     <= '0;
        end else begin
            ptr_q           <= ptr_d;
            resp_valid_q    <= resp_valid_d;
            resp_id_q       <= resp_id_d;
            resp_sum_q      <= resp_sum_d;
            resp_overflow_q <= resp_overflow_d;
            ovf_count_q     <= ovf_count_d;
        end
    end

    assign req_ready     = w_req_ready;
    assign resp_valid    = resp_valid_q;
    assign resp_id       = resp_id_q;
    assign resp_sum      = resp_sum_q;
    assign resp_overflow = resp_overflow_q;
    assign ovf_count     = ovf_count_q;

endmodule
`default_nettype wire

// File: tb/tb_signed_adder_rr_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : tb_signed_adder_rr_arbiter
// Description : Directed self-checking bench for signed_adder_rr_arbiter
//               (N_REQ=4, W=4, CNT_W=8) with hand-computed expectations.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_signed_adder_rr_arbiter;

    logic        clk;
    logic        rst_n;
    logic [3:0]  req_valid;
    logic [3:0]  req_ready;
    logic [15:0] req_a;
    logic [15:0] req_b;
    logic        resp_valid;
    logic        resp_ready;
    logic [1:0]  resp_id;
    logic [3:0]  resp_sum;
    logic        resp_overflow;
    logic [7:0]  ovf_count;
    logic        clr_count;

    int total = 0;
    int bad   = 0;

    signed_adder_rr_arbiter #(.N_REQ(4), .W(4), .CNT_W(8)) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .req_valid     (req_valid),
        .req_ready     (req_ready),
        .req_a         (req_a),
        .req_b         (req_b),
        .resp_valid    (resp_valid),
        .resp_ready    (resp_ready),
        .resp_id       (resp_id),
        .resp_sum      (resp_sum),
        .resp_overflow (resp_overflow),
        .ovf_count     (ovf_count),
        .clr_count     (clr_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk_resp(input string tag, input logic [1:0] id,
                            input logic [3:0] sum, input logic ovf);
        chk({tag, "_valid"}, 32'(resp_valid), 32'd1);
        chk({tag, "_id"},    32'(resp_id), 32'(id));
        chk({tag, "_sum"},   32'(resp_sum), 32'(sum));
        chk({tag, "_ovf"},   32'(resp_overflow), 32'(ovf));
    endtask

    initial begin
        int exp_id;
        rst_n      = 1'b0;
        req_valid  = 4'hF;
        req_a      = '0;
        req_b      = '0;
        resp_ready = 1'b0;
        clr_count  = 1'b0;

        // Reset state, including no grants while reset is held
        #2;
        chk("rst_valid", 32'(resp_valid), 32'd0);
        chk("rst_id", 32'(resp_id), 32'd0);
        chk("rst_sum", 32'(resp_sum), 32'd0);
        chk("rst_ovf", 32'(resp_overflow), 32'd0);
        chk("rst_count", 32'(ovf_count), 32'd0);
        chk("rst_ready", 32'(req_ready), 32'd0);
        req_valid = 4'h0;
        tick();
        tick();
        #3;
        rst_n = 1'b1;
        tick();

        // Single request from requester 0: 3 + 2 = 5
        req_valid   = 4'b0001;
        req_a[3:0]  = 4'd3;
        req_b[3:0]  = 4'd2;
        resp_ready  = 1'b1;
        #1;
        chk("t1_ready", 32'(req_ready), 32'b0001);
        tick();
        req_valid = 4'h0;
        chk_resp("t1", 2'd0, 4'd5, 1'b0);
        tick();
        chk("t1_drain", 32'(resp_valid), 32'd0);

        // All four valid with 4+7: pointer at 0 so grants run 1,2,3,0,1
        req_a     = {4{4'h4}};
        req_b     = {4{4'h7}};
        req_valid = 4'hF;
        for (int k = 1; k <= 5; k++) begin
            exp_id = k % 4;
            #1;
            chk("t2_ready", 32'(req_ready), 32'(1 << exp_id));
            tick();
            chk_resp("t2", 2'(exp_id), 4'hB, 1'b1);
            chk("t2_count", 32'(ovf_count), 32'(k - 1));
        end

        // Backpressure for 3 cycles: result held, nothing granted
        resp_ready = 1'b0;
        for (int k = 0; k < 3; k++) begin
            #1;
            chk("t3_ready_blk", 32'(req_ready), 32'd0);
            tick();
            chk_resp("t3_hold", 2'd1, 4'hB, 1'b1);
            chk("t3_count", 32'(ovf_count), 32'd4);
        end
        resp_ready = 1'b1;
        #1;
        chk("t3_ready_rel", 32'(req_ready), 32'b0100);
        tick();
        chk_resp("t3_next", 2'd2, 4'hB, 1'b1);
        chk("t3_count2", 32'(ovf_count), 32'd5);
        req_valid = 4'h0;
        tick();
        chk("t3_drain", 32'(resp_valid), 32'd0);
        chk("t3_count3", 32'(ovf_count), 32'd6);

        // Signed boundaries on requester 2
        req_a     = '0;
        req_b     = '0;
        req_valid = 4'b0100;
        req_a[11:8] = 4'hC; req_b[11:8] = 4'h9;
        tick();
        chk_resp("t4_m4m7", 2'd2, 4'h5, 1'b1);
        req_a[11:8] = 4'hC; req_b[11:8] = 4'hC;
        tick();
        chk_resp("t4_m4m4", 2'd2, 4'h8, 1'b0);
        req_a[11:8] = 4'h7; req_b[11:8] = 4'hC;
        tick();
        chk_resp("t4_7m4", 2'd2, 4'h3, 1'b0);
        req_a[11:8] = 4'h8; req_b[11:8] = 4'h8;
        tick();
        chk_resp("t4_m8m8", 2'd2, 4'h0, 1'b1);
        chk("t4_count", 32'(ovf_count), 32'd7);
        req_valid = 4'h0;
        tick();
        chk("t4_count2", 32'(ovf_count), 32'd8);
        chk("t4_drain", 32'(resp_valid), 32'd0);

        // Drive the counter to 254, then saturate
        req_a[3:0] = 4'h4;
        req_b[3:0] = 4'h7;
        req_valid  = 4'b0001;
        for (int n = 0; n < 246; n++) tick();
        req_valid = 4'h0;
        tick();
        chk("t5_count254", 32'(ovf_count), 32'd254);
        req_valid = 4'b0001;
        tick();
        chk("t5_pending", 32'(ovf_count), 32'd254);
        tick();
        chk("t5_count255", 32'(ovf_count), 32'd255);
        req_valid = 4'h0;
        tick();
        chk("t5_sat", 32'(ovf_count), 32'd255);
        req_valid = 4'b0001;
        tick();
        req_valid = 4'h0;
        clr_count = 1'b1;
        tick();
        clr_count = 1'b0;
        chk("t5_clr", 32'(ovf_count), 32'd0);

        // Asynchronous reset while a result is held under backpressure
        req_valid = 4'b0001;
        tick();
        tick();
        req_valid  = 4'h0;
        resp_ready = 1'b0;
        tick();
        chk("t6_count_pre", 32'(ovf_count), 32'd1);
        chk("t6_valid_pre", 32'(resp_valid), 32'd1);
        #2;
        rst_n = 1'b0;
        #1;
        chk("t6_valid_rst", 32'(resp_valid), 32'd0);
        chk("t6_count_rst", 32'(ovf_count), 32'd0);
        chk("t6_sum_rst", 32'(resp_sum), 32'd0);
        tick();
        #3;
        rst_n      = 1'b1;
        req_a      = '0;
        req_b      = '0;
        req_a[3:0] = 4'd3;  req_b[3:0]   = 4'd2;
        req_a[15:12] = 4'd1; req_b[15:12] = 4'd1;
        req_valid  = 4'b1001;
        resp_ready = 1'b1;
        #1;
        chk("t6_ready_post", 32'(req_ready), 32'b0001);
        tick();
        req_valid = 4'h0;
        chk_resp("t6_post", 2'd0, 4'd5, 1'b0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire
